stage_link_rx: RTL
==================

Name: stage_link_rx

Overview:
Receiving end of the 4-phase bundled-data req/ack channel between CPU stages running on independent stage clocks (clk_if, clk_id, clk_alu, clk_wb, clk_regfile).
- Instantiated in the consuming stage's domain.
- Synchronises the upstream req, captures the bundled data word, and returns ack.
- Buffers words in a small FIFO and presents them to the local stage via a valid/ready interface.

Parameters:
- DATA_W, 32, width of bundled data word.
- SYNC_STAGES, 2, flops in the req synchroniser (min 2).
- DEPTH, 2, FIFO entries (power of two, min 2).

Ports:
- clk, input, 1, local stage clock.
- reset, input, 1, asynchronous active-high reset.
- req_in, input, 1, upstream 4-phase request (foreign domain).
- data_in, input, DATA_W, bundled data; stable from req_in rise until ack_out rise.
- ack_out, input-side return, output, 1, 4-phase acknowledge (registered).
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, local stage consumes the head word.
- out_data, output, DATA_W, FIFO head word.
- fill_level, output, $clog2(DEPTH)+1, FIFO occupancy.
- xfer_count, output, 8, completed captures, wraps modulo 256.

Behaviour:
- Reset (async assert, released on the next clk edge):
  - ack_out=0, out_valid=0, out_data=0, fill_level=0, xfer_count=0.
  - Synchroniser flops cleared; FSM to IDLE.
- req_s is req_in after SYNC_STAGES flops. With SYNC_STAGES=2, req_in high before edge k gives req_s=1 after edge k+1.
- FSM states: IDLE, CAPTURE, WAIT_LOW.
  - IDLE: ack_out=0.
    - Go to CAPTURE when req_s=1 and fill_level<DEPTH, using the pre-edge fill_level.
    - A pop in the same cycle does not free the slot for this decision.
  - CAPTURE (one cycle): on the exit edge:
    - write data_in to the tail and increment the pointer;
    - set ack_out=1;
    - increment xfer_count;
    - go to WAIT_LOW.
  - WAIT_LOW: ack_out=1; when req_s=0, ack_out=0 and go to IDLE.
- Latency (SYNC_STAGES=2, FIFO empty):
  - req_in rises before edge 1 → req_s=1 after edge 2 → CAPTURE after edge 3.
  - At edge 4: word written, ack_out=1, out_valid=1, out_data=word.
  - req_in falls before edge n → ack_out=0 after edge n+2.
- Backpressure: while full, stay in IDLE with ack_out=0 and req held pending. No data is lost or overwritten.
- Pop: out_valid && out_ready at an edge advances the head and decrements fill_level. A simultaneous write and pop leaves fill_level unchanged.
- out_data is the head register. When empty, out_data holds its last value and out_valid=0.
- Pointers wrap modulo DEPTH. fill_level is exact from 0 to DEPTH.
- xfer_count wraps 255→0.
- data_in is sampled only in CAPTURE. It must not be sampled through the synchroniser.
- Reset mid-handshake: ack_out drops immediately and FIFO contents are discarded. If req_in is still high after reset release, it is treated as a new transfer. Upstream stages share the same reset, so this does not occur in the system.
- out_ready while out_valid=0 is ignored.

Decomposition:
- async_cpu_pkg holds:
  - link_state_t enum {IDLE, CAPTURE, WAIT_LOW};
  - LINK_DATA_W=32;
  - LINK_SYNC_STAGES=2.
- Sub-module sync_bit: parameterised N-flop single-bit synchroniser, async active-high reset to 0. Also reused on the transmitter side for ack.
- FIFO storage stays inline.

Test Plan:
1. Single transfer, data_in=32'hDEADBEEF, req_in rising before edge 1 → ack_out=1 and out_valid=1 after edge 4; out_data=32'hDEADBEEF; xfer_count=1. Drop req_in → ack_out=0 two edges later.
2. Backpressure: out_ready=0, three transfers 32'h1, 32'h2, 32'h3 → first two acked, fill_level=2, ack_out stays 0 for the third. Pulse out_ready once → out_data=32'h2, third word captured, fill_level=2.
3. Simultaneous pop and capture with fill_level=1 → fill_level stays 1 across that edge; order preserved (32'hA then 32'hB).
4. Reset asserted while ack_out=1 with fill_level=2 → ack_out=0, out_valid=0, fill_level=0, xfer_count=0 without waiting for an edge.
5. 256 back-to-back transfers with out_ready=1 → xfer_count wraps to 0. Every word is seen exactly once, in order, with an incrementing pattern.
6. Random req_in phase relative to clk (jittered 7/9/11/13 ns upstream periods) → no dropped or duplicated words over 1000 transfers; scoreboard matches.

Source files
------------

// File: rtl/async_cpu_pkg.sv
// Shared types and defaults for the stage-to-stage 4-phase bundled-data links.
package async_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } link_state_t;

    localparam int LINK_DATA_W      = 32;
    localparam int LINK_SYNC_STAGES = 2;
    localparam int LINK_DEPTH       = 2;
    localparam int LINK_XFER_W      = 8;

endpackage

// File: rtl/stage_link_rx_if.sv
// Bundle of the upstream req/ack/data channel and the local valid/ready output.
interface stage_link_rx_if
    import async_cpu_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int DEPTH  = LINK_DEPTH
);

    // Upstream: 4-phase; data_in is stable from req_in rise until ack_out rise.
    // Local: a word transfers on every edge where out_valid && out_ready are
    // both high; out_valid never depends on out_ready, and out_ready while
    // out_valid is low has no effect.
    logic                    req_in;
    logic [DATA_W-1:0]       data_in;
    logic                    ack_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [$clog2(DEPTH):0]  fill_level;
    logic [LINK_XFER_W-1:0]  xfer_count;

    modport master (
        output req_in, data_in, out_ready,
        input  ack_out, out_valid, out_data, fill_level, xfer_count
    );

    modport slave (
        input  req_in, data_in, out_ready,
        output ack_out, out_valid, out_data, fill_level, xfer_count
    );

endinterface

// File: rtl/sync_bit.sv
// N-flop single-bit synchroniser; also used on the transmit side for ack.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/stage_link_rx.sv
// Receive end of a 4-phase bundled-data link: sync req, capture word, ack,
// and buffer words in a small FIFO drained through valid/ready.
module stage_link_rx
    import async_cpu_pkg::*;
#(
    parameter int DATA_W      = LINK_DATA_W,
    parameter int SYNC_STAGES = LINK_SYNC_STAGES,
    parameter int DEPTH       = LINK_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    stage_link_rx_if.slave     link,
    output link_state_t        state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                     req_s;
    link_state_t              state_q, state_d;
    logic                     ack_q, ack_d;
    logic [PTR_W-1:0]         wr_q, wr_d;
    logic [PTR_W-1:0]         rd_q, rd_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [DATA_W-1:0]        head_q, head_d;
    logic [LINK_XFER_W-1:0]   xfer_q;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wr_en;
    logic                     pop;
    logic                     has_room;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (link.req_in),
        .q     (req_s)
    );

    // The room decision uses the pre-edge count, so a pop in the same cycle
    // only helps on the following cycle.
    assign has_room = (count_q < CNT_W'(DEPTH));
    assign wr_en    = (state_q == CAPTURE);
    assign pop      = (count_q != '0) && link.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s && has_room) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                ack_d   = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_d    = wr_q + PTR_W'(wr_en);
        rd_d    = rd_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        head_d  = head_q;
        // A word written into an empty (or just-emptied) FIFO is the new head.
        if (count_d != '0) begin
            if (wr_en && (wr_q == rd_d)) begin
                head_d = link.data_in;
            end else begin
                head_d = mem[rd_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            xfer_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
            if (wr_en) begin
                xfer_q <= xfer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q] <= link.data_in;
        end
    end

    assign link.ack_out    = ack_q;
    assign link.out_valid  = (count_q != '0);
    assign link.out_data   = head_q;
    assign link.fill_level = count_q;
    assign link.xfer_count = xfer_q;
    assign state           = state_q;

endmodule
